// File: rtl/riscv_32im_pkg.sv
// riscv_32im_pkg: shared types and constants for the data-side memory subsystem
package riscv_32im_pkg;
    localparam logic [4:0] MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] GPIO        = 5'h10;

    typedef enum logic [1:0] {SEL_RAM, SEL_MMIO, SEL_NONE} dmem_sel_t;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        merge_be = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge_be[8*i +: 8] = new_v[8*i +: 8];
    endfunction
endpackage

// File: rtl/dmem_subsys_if.sv
// dmem_subsys_if: LSU-side DMEM port (address, write data, byte enables, strobe, read data)
interface dmem_subsys_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rdata;
    modport master (output addr, wdata, be, we, input rdata);
    modport slave  (input addr, wdata, be, we, output rdata);
endinterface

// File: rtl/dmem_subsys_ram.sv
// dmem_ram: single-port synchronous read-first byte-enabled RAM
module dmem_ram #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    input  logic          we,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        rdata <= mem[addr];
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/dmem_subsys.sv
// dmem_subsys: data RAM plus MMIO window (64-bit machine timer, GPIO) behind the LSU DMEM port
module dmem_subsys
    import riscv_32im_pkg::*;
#(
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_subsys_if.slave  bus,
    output logic          timer_irq_o,
    output logic [31:0]   gpio_o,
    output logic          decode_err_o
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [32:0]   ram_off;
    dmem_sel_t     sel, sel_q;
    logic [4:0]    off;
    logic          mmio_wr, wr_mlo, wr_mhi, wr_clo, wr_chi, wr_gpio, tick;
    logic [TW-1:0] tick_cnt;
    logic [63:0]   mtime, mtime_d, mtimecmp, mtimecmp_d;
    logic [31:0]   gpio_d, mmio_rd, mmio_q, ram_rd;

    assign ram_off = {1'b0, bus.addr} - {1'b0, RAM_BASE};
    assign sel     = (!ram_off[32] && ram_off < 33'(RAM_WORDS) * 33'd4) ? SEL_RAM :
                     (bus.addr[31:5] == MMIO_BASE[31:5]) ? SEL_MMIO : SEL_NONE;
    assign off     = bus.addr[4:0];
    assign mmio_wr = bus.we && |bus.be && sel == SEL_MMIO;
    assign wr_mlo  = mmio_wr && off == MTIME_LO;
    assign wr_mhi  = mmio_wr && off == MTIME_HI;
    assign wr_clo  = mmio_wr && off == MTIMECMP_LO;
    assign wr_chi  = mmio_wr && off == MTIMECMP_HI;
    assign wr_gpio = mmio_wr && off == GPIO;
    assign tick    = tick_cnt == TW'(TICK_DIV - 1);

    // a write to either mtime half swallows that cycle's increment
    assign mtime_d = (wr_mlo || wr_mhi) ?
                     {wr_mhi ? merge_be(mtime[63:32], bus.wdata, bus.be) : mtime[63:32],
                      wr_mlo ? merge_be(mtime[31:0], bus.wdata, bus.be) : mtime[31:0]} :
                     tick ? mtime + 64'd1 : mtime;
    assign mtimecmp_d = {wr_chi ? merge_be(mtimecmp[63:32], bus.wdata, bus.be) : mtimecmp[63:32],
                         wr_clo ? merge_be(mtimecmp[31:0], bus.wdata, bus.be) : mtimecmp[31:0]};
    assign gpio_d  = wr_gpio ? merge_be(gpio_o, bus.wdata, bus.be) : gpio_o;
    assign mmio_rd = off == MTIME_LO    ? mtime[31:0]     :
                     off == MTIME_HI    ? mtime[63:32]    :
                     off == MTIMECMP_LO ? mtimecmp[31:0]  :
                     off == MTIMECMP_HI ? mtimecmp[63:32] :
                     off == GPIO        ? gpio_o          : '0;
    assign bus.rdata = sel_q == SEL_RAM ? ram_rd : sel_q == SEL_MMIO ? mmio_q : '0;

    dmem_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk_i (clk_i),
        .addr  (ram_off[AW+1:2]),
        .wdata (bus.wdata),
        .be    (bus.be),
        .we    (bus.we && sel == SEL_RAM && !rst_i),
        .rdata (ram_rd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q        <= SEL_NONE;
            mmio_q       <= '0;
            tick_cnt     <= '0;
            mtime        <= '0;
            mtimecmp     <= '1;
            gpio_o       <= '0;
            timer_irq_o  <= 1'b0;
            decode_err_o <= 1'b0;
        end else begin
            sel_q        <= sel;
            mmio_q       <= mmio_rd;
            tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
            mtime        <= mtime_d;
            mtimecmp     <= mtimecmp_d;
            gpio_o       <= gpio_d;
            timer_irq_o  <= mtime >= mtimecmp;
            decode_err_o <= bus.we && sel == SEL_NONE;
        end
    end
endmodule
